pc_sequencer: RTL and testbench

Owns the fetch-stage program counter of the pipelined MIPS core. Each cycle it picks the next PC from four sources: sequential PC+4, branch target, j/jal target, or jr register target, plus an exception vector. It tracks jr operand readiness, holds redirects that arrive while fetch is stalled, and generates the F/D flush. It is the single writer of pcf.

---
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// Fetch-stage PC owner: selects sequential, branch, jump, jr or exception target,
// parks redirects that arrive while fetch is stalled, and drives the F/D flush.
module pc_sequencer #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h80000180)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stallf,
  input  logic             imem_ready,
  input  logic             exc,
  input  logic             branch_taken,
  input  logic [WIDTH-1:0] branch_target,
  input  logic             jump,
  input  logic [WIDTH-1:0] jump_target,
  input  logic             jr,
  input  logic [WIDTH-1:0] jr_target,
  input  logic             jr_src_ready,
  output logic [WIDTH-1:0] pcf,
  output logic             fetch_valid,
  output logic             flushd,
  output logic [1:0]       seq_state
);

  typedef enum logic [1:0] {
    BOOT    = 2'd0,
    RUN     = 2'd1,
    WAIT_JR = 2'd2,
    HOLD    = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] ALIGN = ~WIDTH'(3);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pcf_q, pcf_d;
  logic [WIDTH-1:0] pending_q, pending_d;

  logic             advance, jr_go, redir;
  logic [WIDTH-1:0] tgt, wait_tgt, hold_tgt;

  always_comb begin
    advance = imem_ready & ~stallf;
    jr_go   = jr & jr_src_ready;
    // An unresolved jr outranks jump, so jump only counts when no jr is decoded.
    redir   = exc | branch_taken | jr_go | (jump & ~jr);

    if (exc)               tgt = EXC_VECTOR;
    else if (branch_taken) tgt = branch_target & ALIGN;
    else if (jr_go)        tgt = jr_target & ALIGN;
    else                   tgt = jump_target & ALIGN;

    wait_tgt = exc ? EXC_VECTOR : (jr_target & ALIGN);
    hold_tgt = exc ? EXC_VECTOR : pending_q;

    state_d     = state_q;
    pcf_d       = pcf_q;
    pending_d   = pending_q;
    fetch_valid = 1'b0;
    flushd      = 1'b0;

    unique case (state_q)
      BOOT: state_d = RUN;
      RUN: begin
        if (redir) begin
          if (advance) begin
            pcf_d  = tgt;
            flushd = 1'b1;
          end else begin
            pending_d = tgt;
            state_d   = HOLD;
          end
        end else if (jr) begin
          state_d = WAIT_JR;
        end else if (advance) begin
          pcf_d       = pcf_q + WIDTH'(4);
          fetch_valid = 1'b1;
        end
      end
      WAIT_JR: begin
        if (exc || jr_src_ready) begin
          if (advance) begin
            pcf_d   = wait_tgt;
            flushd  = 1'b1;
            state_d = RUN;
          end else begin
            pending_d = wait_tgt;
            state_d   = HOLD;
          end
        end
      end
      HOLD: begin
        pending_d = hold_tgt;
        if (advance) begin
          pcf_d   = hold_tgt;
          flushd  = 1'b1;
          state_d = RUN;
        end
      end
      default: state_d = BOOT;
    endcase

    if (!reset) begin
      fetch_valid = 1'b0;
      flushd      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= BOOT;
      pcf_q     <= RESET_PC;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      pcf_q     <= pcf_d;
      pending_q <= pending_d;
    end
  end

  assign pcf       = pcf_q;
  assign seq_state = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed vector bench for pc_sequencer: a table of per-cycle inputs and
// expected outputs, followed by hand sequences for PC wrap and reset in HOLD.
module tb_pc_sequencer;

  localparam logic [31:0] EXC = 32'h80000180;

  logic        clk = 1'b0;
  logic        reset, stallf, imem_ready, exc, branch_taken, jump, jr, jr_src_ready;
  logic [31:0] branch_target, jump_target, jr_target, pcf;
  logic        fetch_valid, flushd;
  logic [1:0]  seq_state;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .stallf       (stallf),
    .imem_ready   (imem_ready),
    .exc          (exc),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .jr           (jr),
    .jr_target    (jr_target),
    .jr_src_ready (jr_src_ready),
    .pcf          (pcf),
    .fetch_valid  (fetch_valid),
    .flushd       (flushd),
    .seq_state    (seq_state)
  );

  typedef struct {
    logic        rst, stl, rdy, ex, br;
    logic [31:0] bt;
    logic        jmp;
    logic [31:0] jt;
    logic        jrr;
    logic [31:0] jrt;
    logic        jrok;
    logic [31:0] e_pcf;
    logic        e_fv, e_fl;
    logic [1:0]  e_st;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic rst, logic stl, logic rdy, logic ex, logic br,
                              logic [31:0] bt, logic jmp, logic [31:0] jt, logic jrr,
                              logic [31:0] jrt, logic jrok, logic [31:0] e_pcf,
                              logic e_fv, logic e_fl, logic [1:0] e_st);
    vec_t v;
    v.rst = rst; v.stl = stl; v.rdy = rdy; v.ex = ex; v.br = br; v.bt = bt;
    v.jmp = jmp; v.jt = jt; v.jrr = jrr; v.jrt = jrt; v.jrok = jrok;
    v.e_pcf = e_pcf; v.e_fv = e_fv; v.e_fl = e_fl; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Drive on the falling edge, compare 1ns later, well before the next rising edge.
  task automatic apply(input string tag, input vec_t v);
    @(negedge clk);
    reset = v.rst; stallf = v.stl; imem_ready = v.rdy; exc = v.ex;
    branch_taken = v.br; branch_target = v.bt; jump = v.jmp; jump_target = v.jt;
    jr = v.jrr; jr_target = v.jrt; jr_src_ready = v.jrok;
    #1;
    chk({tag, ".pcf"},         pcf,                 v.e_pcf);
    chk({tag, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, v.e_fv});
    chk({tag, ".flushd"},      {31'd0, flushd},      {31'd0, v.e_fl});
    chk({tag, ".seq_state"},   {30'd0, seq_state},   {30'd0, v.e_st});
  endtask

  initial begin
    reset = 1'b0; stallf = 1'b0; imem_ready = 1'b1; exc = 1'b0;
    branch_taken = 1'b0; branch_target = '0; jump = 1'b0; jump_target = '0;
    jr = 1'b0; jr_target = '0; jr_src_ready = 1'b0;

    //             rst stl rdy ex br bt          jmp jt          jr jrt         ok  pcf           fv fl st
    vecs.push_back(mk(0, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h0,        0, 0, 0));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h0,        1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h4,        1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h8,        1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'hC,        1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 1, 32'h40,     0, 32'h0,       0, 32'h0,      0, 32'h10,       0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h40,       1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       1, 32'h0,      0, 32'h44,       0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       1, 32'h0,      0, 32'h44,       0, 0, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       1, 32'h123,    1, 32'h44,       0, 1, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h120,      1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,      1, 32'h200,     0, 32'h0,      0, 32'h124,      0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 1, 32'h40,     0, 32'h0,       0, 32'h0,      0, 32'h124,      0, 0, 3));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h124,      0, 1, 3));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h200,      1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 1, 1, 32'h40,     1, 32'h300,     0, 32'h0,      0, 32'h204,      0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, EXC,          1, 0, 1));
    vecs.push_back(mk(1, 1, 1, 0, 0, 32'h0,      1, 32'h300,     0, 32'h0,      0, 32'h80000184, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h80000184, 0, 0, 3));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h80000184, 0, 1, 3));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, EXC,          1, 0, 1));
    vecs.push_back(mk(1, 0, 0, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h80000184, 0, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h80000184, 1, 0, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       1, 32'h0,      0, 32'h80000188, 0, 0, 1));
    vecs.push_back(mk(1, 1, 1, 1, 0, 32'h0,      0, 32'h0,       1, 32'h600,    1, 32'h80000188, 0, 0, 2));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h80000188, 0, 1, 3));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      1, 32'h207,     0, 32'h0,      0, EXC,          0, 1, 1));
    vecs.push_back(mk(1, 0, 1, 0, 0, 32'h0,      0, 32'h0,       0, 32'h0,      0, 32'h204,      1, 0, 1));

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) apply($sformatf("v%0d", i), vecs[i]);

    // PC+4 wraps past the top of the address space.
    apply("wrap0", mk(1, 0, 1, 0, 0, 32'h0, 1, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h208,      0, 1, 1));
    apply("wrap1", mk(1, 0, 1, 0, 0, 32'h0, 0, 32'h0,        0, 32'h0, 0, 32'hFFFFFFFC, 1, 0, 1));
    apply("wrap2", mk(1, 0, 1, 0, 0, 32'h0, 0, 32'h0,        0, 32'h0, 0, 32'h0,        1, 0, 1));

    // Reset while a redirect is parked in HOLD must drop it.
    apply("rh0", mk(1, 1, 1, 0, 0, 32'h0, 1, 32'h500, 0, 32'h0, 0, 32'h4, 0, 0, 1));
    apply("rh1", mk(1, 1, 1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0, 0, 32'h4, 0, 0, 3));
    apply("rh2", mk(0, 0, 1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0, 0, 32'h4, 0, 0, 3));
    apply("rh3", mk(0, 0, 1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0, 0));
    apply("rh4", mk(1, 0, 1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 0, 0, 0));
    apply("rh5", mk(1, 0, 1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0, 0, 32'h0, 1, 0, 1));
    apply("rh6", mk(1, 0, 1, 0, 0, 32'h0, 0, 32'h0,   0, 32'h0, 0, 32'h4, 1, 0, 1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
